// File: rtl/dsp_config_loader_pkg.sv
// Shared types and constants for the DSP configuration-chain loader.
package dsp_cfg_pkg;

  localparam int unsigned DEF_CONFIG_WIDTH = 20;
  localparam int unsigned DEF_WORD_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT
  } state_t;

  // Bits taken from the final word of a frame; its upper bits are discarded.
  function automatic int unsigned last_word_bits(input int unsigned cw,
                                                 input int unsigned ww,
                                                 input int unsigned nw);
    return cw - (nw - 1) * ww;
  endfunction

endpackage

// File: rtl/dsp_config_shifter.sv
// Loadable right-shift register with a per-word remaining-bit counter.
// On load, bit 0 is presented by the caller, so only the remaining bits are held.
module dsp_config_shifter #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              load,
  input  logic                              shift,
  input  logic [WORD_WIDTH-1:0]             data,
  input  logic [$clog2(WORD_WIDTH+1)-1:0]   nbits,
  output logic                              head,
  output logic                              last
);

  localparam int unsigned CNT_W = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] sr;
  logic [CNT_W-1:0]      remaining;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr        <= '0;
      remaining <= '0;
    end else if (load) begin
      sr        <= data >> 1;
      remaining <= nbits - CNT_W'(1);
    end else if (shift) begin
      sr        <= sr >> 1;
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign head = sr[0];
  assign last = (remaining == '0);

endmodule

// File: rtl/dsp_config_loader.sv
// Serial configuration transmitter: valid/ready words in, LSB-first bit stream out.
// Optional word parity checking is enabled by defining DSP_CONFIG_LOADER_PARITY_EN.
module dsp_config_loader
  import dsp_cfg_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = DEF_CONFIG_WIDTH,
  parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH
) (
  input  logic                              clk,
  input  logic                              RSTN,
  input  logic                              start,
  input  logic [WORD_WIDTH-1:0]             word_data,
  input  logic                              word_valid,
  output logic                              word_ready,
  output logic                              configuration_input,
  output logic                              configuration_enable,
  output logic                              busy,
  output logic                              config_done,
  output logic [$clog2(CONFIG_WIDTH+1)-1:0] bit_count
`ifdef DSP_CONFIG_LOADER_PARITY_EN
  ,
  input  logic                              word_parity,
  output logic                              parity_err
`endif
);

  localparam int unsigned NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned LAST_BITS = last_word_bits(CONFIG_WIDTH, WORD_WIDTH, NUM_WORDS);
  localparam int unsigned BC_W      = $clog2(CONFIG_WIDTH + 1);
  localparam int unsigned CNT_W     = $clog2(WORD_WIDTH + 1);
  localparam logic [BC_W-1:0] FULL  = BC_W'(CONFIG_WIDTH);

  state_t           state, state_next;
  logic             head, last;
  logic             start_accept, handshake, parity_ok;
  logic             load, shift, frame_end, abort, more_bits;
  logic [CNT_W-1:0] nbits;
  int unsigned      bits_left;

  assign more_bits = (bit_count != FULL);

`ifdef DSP_CONFIG_LOADER_PARITY_EN
  assign parity_ok = ((^word_data) == word_parity);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_next;
  end

  // The last word of a frame is truncated; every other word is full width.
  always_comb begin
    bits_left = CONFIG_WIDTH - 32'(bit_count);
    nbits     = (bits_left > WORD_WIDTH) ? CNT_W'(WORD_WIDTH) : CNT_W'(LAST_BITS);
  end

  always_comb begin
    word_ready   = 1'b0;
    start_accept = 1'b0;
    shift        = 1'b0;
    frame_end    = 1'b0;
    unique case (state)
      ST_IDLE:  start_accept = start;
      ST_FETCH: word_ready   = 1'b1;
      ST_SHIFT: begin
        // Ready during a word's last bit lets the next word follow with no bubble.
        if (!last)          shift      = 1'b1;
        else if (more_bits) word_ready = 1'b1;
        else                frame_end  = 1'b1;
      end
      default: ;
    endcase
    handshake = word_ready && word_valid;
    load      = handshake && parity_ok;
    abort     = handshake && !parity_ok;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        if (abort)     state_next = ST_IDLE;
        else if (load) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last) begin
          if (frame_end || abort) state_next = ST_IDLE;
          else if (!load)         state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  dsp_config_shifter #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_shifter (
    .clk   (clk),
    .rstn  (RSTN),
    .load  (load),
    .shift (shift),
    .data  (word_data),
    .nbits (nbits),
    .head  (head),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      configuration_input  <= 1'b0;
      configuration_enable <= 1'b0;
      busy                 <= 1'b0;
      config_done          <= 1'b0;
      bit_count            <= '0;
    end else begin
      configuration_enable <= load || shift;
      config_done          <= frame_end;
      if (load)       configuration_input <= word_data[0];
      else if (shift) configuration_input <= head;
      if (start_accept) begin
        busy      <= 1'b1;
        bit_count <= '0;
      end else begin
        if (frame_end || abort) busy <= 1'b0;
        if ((load || shift) && more_bits) bit_count <= bit_count + BC_W'(1);
      end
    end
  end

`ifdef DSP_CONFIG_LOADER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!RSTN)             parity_err <= 1'b0;
    else if (start_accept) parity_err <= 1'b0;
    else if (abort)        parity_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dsp_config_loader.sv
// Bench for dsp_config_loader: directed table, corner sequences and random frames vs a frame-level model.
// Parity scenarios are included when DSP_CONFIG_LOADER_PARITY_EN is defined.
module tb_dsp_config_loader;

  localparam int CW = 20;
  localparam int WW = 8;

  logic       clk = 1'b0;
  logic       RSTN, start, word_valid;
  logic [7:0] word_data;
  logic       word_ready, configuration_input, configuration_enable, busy, config_done;
  logic [4:0] bit_count;
`ifdef DSP_CONFIG_LOADER_PARITY_EN
  logic       word_parity, parity_err;
`endif

  dsp_config_loader #(
    .CONFIG_WIDTH(CW),
    .WORD_WIDTH  (WW)
  ) dut (
    .clk                 (clk),
    .RSTN                (RSTN),
    .start               (start),
    .word_data           (word_data),
    .word_valid          (word_valid),
    .word_ready          (word_ready),
    .configuration_input (configuration_input),
    .configuration_enable(configuration_enable),
    .busy                (busy),
    .config_done         (config_done),
    .bit_count           (bit_count)
`ifdef DSP_CONFIG_LOADER_PARITY_EN
    ,
    .word_parity         (word_parity),
    .parity_err          (parity_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  w0, w1, w2;
    int          g0, g1, g2;
    logic [19:0] exp_serial;
    int          exp_done;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int drv_timeout;
  bit en_q[$], cin_q[$], done_q[$], busy_q[$], perr_q[$];
  int bc_q[$];
  bit exp_en[$], exp_bit[$];
  logic [19:0] got_serial;
  int got_done, got_en;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits `g[wi]` ready cycles with valid low before offering each word.
  task automatic drive_words(input logic [7:0] w [3], input int g [3], input int bad);
    int cnt;
    bit sent;
    drv_timeout = 0;
    for (int wi = 0; wi < 3; wi++) begin
      cnt  = 0;
      sent = 0;
      for (int c = 0; c < 60 && !sent; c++) begin
        @(negedge clk);
        if (word_ready && cnt == g[wi]) begin
          word_data  = w[wi];
          word_valid = 1'b1;
`ifdef DSP_CONFIG_LOADER_PARITY_EN
          word_parity = (^w[wi]) ^ (wi == bad);
`endif
          @(posedge clk);
          sent = 1;
        end else begin
          word_valid = 1'b0;
          if (word_ready) cnt++;
        end
      end
      if (!sent) drv_timeout++;
      if (wi == bad) break;
    end
    #1 word_valid = 1'b0;
  endtask

  task automatic monitor(input int budget, input bit restart);
    en_q.delete(); cin_q.delete(); done_q.delete(); busy_q.delete(); perr_q.delete(); bc_q.delete();
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      en_q.push_back(configuration_enable);
      cin_q.push_back(configuration_input);
      done_q.push_back(config_done);
      busy_q.push_back(busy);
      bc_q.push_back(int'(bit_count));
`ifdef DSP_CONFIG_LOADER_PARITY_EN
      perr_q.push_back(parity_err);
`else
      perr_q.push_back(1'b0);
`endif
      if (config_done) begin
        if (restart) begin
          start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
        break;
      end
    end
  endtask

  task automatic start_noise(input int at);
    if (at > 0) begin
      repeat (at) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] w [3], input int g [3], input int bad,
                           input bit skip_start, input bit restart, input int noise, input int budget);
    if (!skip_start) begin
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    fork
      drive_words(w, g, bad);
      monitor(budget, restart);
      start_noise(noise);
    join
    got_serial = '0;
    got_en     = 0;
    got_done   = -1;
    for (int i = 0; i < en_q.size(); i++) begin
      if (en_q[i]) begin
        if (got_en < CW) got_serial[got_en] = cin_q[i];
        got_en++;
      end
      if (done_q[i] && got_done < 0) got_done = i;
    end
  endtask

  // Expected per-cycle enable/bit timeline: one FETCH cycle plus stalls, then bits, then the done cycle.
  task automatic build_model(input logic [7:0] w [3], input int g [3]);
    int nb;
    exp_en.delete();
    exp_bit.delete();
    for (int i = 0; i < g[0] + 1; i++) begin exp_en.push_back(0); exp_bit.push_back(0); end
    for (int wi = 0; wi < 3; wi++) begin
      if (wi > 0) for (int i = 0; i < g[wi]; i++) begin exp_en.push_back(0); exp_bit.push_back(0); end
      nb = (CW - WW * wi > WW) ? WW : CW - WW * wi;
      for (int b = 0; b < nb; b++) begin exp_en.push_back(1); exp_bit.push_back(w[wi][b]); end
    end
    exp_en.push_back(0);
    exp_bit.push_back(0);
  endtask

  task automatic check_frame(input logic [7:0] w [3], input int g [3]);
    int mism, bcm, bm, running;
    build_model(w, g);
    mism = 0; bcm = 0; bm = 0; running = 0;
    for (int i = 0; i < exp_en.size(); i++) begin
      if (i >= en_q.size()) mism++;
      else if (en_q[i] != exp_en[i] || (exp_en[i] && cin_q[i] != exp_bit[i])) mism++;
    end
    for (int i = 0; i < en_q.size(); i++) begin
      if (en_q[i]) running++;
      if (bc_q[i] != running) bcm++;
      if (i < got_done && busy_q[i] != 1'b1) bm++;
    end
    check("driver_timeout", drv_timeout, 0);
    check("done_cycle", got_done, exp_en.size() - 1);
    check("waveform_mismatches", mism, 0);
    check("enable_cycles", got_en, CW);
    check("bit_count_track", bcm, 0);
    check("busy_track", bm, 0);
    if (got_done >= 0) begin
      check("bit_count_at_done", bc_q[got_done], CW);
      check("busy_at_done", busy_q[got_done], 0);
    end
  endtask

  task automatic idle_after();
    @(negedge clk);
    check("done_single_cycle", config_done, 0);
    check("idle_busy", busy, 0);
    check("idle_enable", configuration_enable, 0);
    check("bit_count_saturated", bit_count, CW);
  endtask

  initial begin
    vec_t        tbl [4];
    logic [7:0]  wa [3];
    int          ga [3];
    int          cnt, acc;

    tbl[0] = '{8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 20'hF3CA5, 21};
    tbl[1] = '{8'hA5, 8'h3C, 8'h0F, 0, 3, 0, 20'hF3CA5, 24};
    tbl[2] = '{8'h12, 8'h34, 8'hFF, 0, 0, 0, 20'hF3412, 21};
    tbl[3] = '{8'hC3, 8'h00, 8'hF7, 2, 1, 2, 20'h700C3, 26};

    RSTN = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0;
`ifdef DSP_CONFIG_LOADER_PARITY_EN
    word_parity = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_enable", configuration_enable, 0);
    check("reset_cin", configuration_input, 0);
    check("reset_busy", busy, 0);
    check("reset_done", config_done, 0);
    check("reset_bit_count", bit_count, 0);
    check("reset_ready", word_ready, 0);
    @(posedge clk);
    #1 RSTN = 1'b1;

    // Valid while idle must be ignored.
    word_valid = 1'b1; word_data = 8'hFF;
    acc = 0;
    repeat (4) begin @(negedge clk); acc += int'(busy) + int'(configuration_enable) + int'(word_ready); end
    word_valid = 1'b0;
    check("idle_valid_ignored", acc, 0);

    foreach (tbl[i]) begin
      wa = '{tbl[i].w0, tbl[i].w1, tbl[i].w2};
      ga = '{tbl[i].g0, tbl[i].g1, tbl[i].g2};
      run_frame(wa, ga, -1, 0, 0, 0, 60);
      check("table_serial", int'(got_serial), int'(tbl[i].exp_serial));
      check("table_done_cycle", got_done, tbl[i].exp_done);
      check_frame(wa, ga);
      idle_after();
    end

    // Start coincident with config_done starts the next frame immediately.
    wa = '{8'hA5, 8'h3C, 8'h0F};
    ga = '{0, 0, 0};
    run_frame(wa, ga, -1, 0, 1, 0, 60);
    check_frame(wa, ga);
    wa = '{8'h5A, 8'h81, 8'h06};
    ga = '{1, 0, 0};
    run_frame(wa, ga, -1, 1, 0, 0, 60);
    check("chained_first_busy", busy_q[0], 1);
    check_frame(wa, ga);
    idle_after();

    // Start pulses while busy are ignored.
    ga = '{0, 2, 1};
    run_frame(wa, ga, -1, 0, 0, 5, 60);
    check_frame(wa, ga);
    idle_after();

    // Reset at the 11th bit abandons the frame without config_done.
    wa = '{8'hA5, 8'h3C, 8'h0F};
    ga = '{0, 0, 0};
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    fork
      drive_words(wa, ga, -1);
      begin
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 11; c++) begin
          @(negedge clk);
          if (configuration_enable) cnt++;
        end
        check("reset_reached_bit11", cnt, 11);
        RSTN = 1'b0;
        @(negedge clk);
        check("midreset_enable", configuration_enable, 0);
        check("midreset_cin", configuration_input, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", config_done, 0);
        check("midreset_bit_count", bit_count, 0);
        check("midreset_ready", word_ready, 0);
        RSTN = 1'b1;
        acc = 0;
        repeat (5) begin @(negedge clk); acc += int'(config_done) + int'(configuration_enable); end
        check("no_done_after_reset", acc, 0);
      end
    join
    run_frame(wa, ga, -1, 0, 0, 0, 60);
    check_frame(wa, ga);
    idle_after();

`ifdef DSP_CONFIG_LOADER_PARITY_EN
    // Wrong parity on the second word aborts after the first word's bits.
    run_frame(wa, ga, 1, 0, 0, 0, 40);
    check("parity_enable_cycles", got_en, 8);
    check("parity_no_done", got_done, -1);
    check("parity_err_before", perr_q[8], 0);
    check("parity_err_set", perr_q[9], 1);
    check("parity_enable_drop", en_q[9], 0);
    check("parity_err_sticky", perr_q[39], 1);
    check("parity_busy_clear", busy_q[39], 0);
    run_frame(wa, ga, -1, 0, 0, 0, 60);
    check("parity_err_cleared", perr_q[0], 0);
    check_frame(wa, ga);
    idle_after();
`endif

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 3; i++) begin
        wa[i] = 8'($urandom);
        ga[i] = (i == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      end
      run_frame(wa, ga, -1, 0, 0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 10)) : 0, 70);
      check_frame(wa, ga);
      idle_after();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_config_loader.md
Name: dsp_config_loader

Overview:
- Serial configuration transmitter for the configuration chain of the proposed DSP blocks.
- Accepts configuration words over a valid/ready stream.
- Serialises each frame LSB-first onto configuration_input, qualified per bit by configuration_enable, which drive the DSP's configuration_input/configuration_enable pins.
- One frame = CONFIG_WIDTH bits. Sits between the bitstream source and a DSP instance or its freezer wrapper.

Parameters:
- CONFIG_WIDTH, 20, total configuration bits per frame (≥1).
- WORD_WIDTH, 8, data bits per input word (≥1).
- NUM_WORDS, ceil(CONFIG_WIDTH/WORD_WIDTH), derived localparam; not overridable.

Ports:
- clk  input  1  clock; all logic on rising edge.
- RSTN  input  1  synchronous active-low reset.
- start  input  1  request a new frame; sampled only in IDLE.
- word_data  input  WORD_WIDTH  configuration word; bit 0 is shifted first.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader accepts word this cycle (combinational from state).
- configuration_input  output  1  serial config bit (registered).
- configuration_enable  output  1  qualifies configuration_input (registered).
- busy  output  1  frame in progress (registered).
- config_done  output  1  one-cycle pulse at frame end (registered).
- bit_count  output  $clog2(CONFIG_WIDTH+1)  bits shifted so far in current frame (registered).

Behaviour:
- Reset (RSTN=0 at clk edge): state IDLE; configuration_input, configuration_enable, busy, config_done and bit_count all 0; shift register cleared. Reset mid-frame abandons the frame silently, with no config_done.
- States: IDLE, FETCH, SHIFT.
- IDLE:
  - word_ready=0.
  - start=1 → FETCH; busy=1 and bit_count=0 from the next cycle.
- FETCH:
  - word_ready=1.
  - word_valid&&word_ready → load shift register with word_data; set word_bits = min(WORD_WIDTH, CONFIG_WIDTH−bit_count); → SHIFT.
- SHIFT, each cycle:
  - Register configuration_input=sr[0] and configuration_enable=1; shift right; bit_count+1.
  - First enable cycle is the cycle immediately after the accepting handshake (latency 1).
- Gapless chaining:
  - During the last bit of a word, when bits remain in the frame, word_ready=1.
  - A handshake then reloads the shift register and stays in SHIFT, so enable stays high with no bubble.
  - No handshake → FETCH; configuration_enable=0 in every stall cycle. configuration_input holds its last value, don't-care.
- Last word of frame:
  - Only CONFIG_WIDTH−(NUM_WORDS−1)·WORD_WIDTH low bits are shifted; upper bits are discarded.
  - word_ready=0 during its last bit.
- Frame end: the cycle after the final enable cycle has configuration_enable=0, config_done=1 (single cycle) and busy=0; state → IDLE.
- Frame length: exactly CONFIG_WIDTH enable-high cycles. Back-to-back input gives CONFIG_WIDTH consecutive enable cycles.
- start while busy: ignored.
- start in the same cycle as config_done: accepted, because the state is already IDLE in that cycle.
- word_valid while word_ready=0: ignored; the source must hold word_data until the handshake.
- bit_count saturates at CONFIG_WIDTH and clears on the next accepted start.

Optional Feature:
- Macro: DSP_CONFIG_LOADER_PARITY_EN.
- Defined:
  - Extra input word_parity (1 bit, even parity over word_data) and extra output parity_err (1 bit, registered, sticky).
  - A handshake with parity mismatch aborts the frame: enable drops next cycle, parity_err=1, no config_done, state → IDLE.
  - parity_err clears on the next accepted start or on reset.
- Undefined: ports absent; no checking.

Decomposition:
- Shared package dsp_cfg_pkg holds:
  - state enum (IDLE/FETCH/SHIFT);
  - default CONFIG_WIDTH/WORD_WIDTH constants;
  - function computing last-word bit count.
- One natural sub-module: dsp_config_shifter (loadable right-shift register with a per-word bit counter and last-bit flag). The FSM and handshake stay in the top.

Test Plan:
- Defaults, start, words 0xA5, 0x3C, 0x0F with valid held high → 20 consecutive enable cycles, serial 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; config_done one cycle after the 20th bit; bit_count=20.
- Stall: delay the second word by 3 cycles → enable low exactly 3 cycles between bit 8 and bit 9; total enable cycles still 20.
- Last word 0xFF → only 4 ones shifted; upper nibble never appears; enable low after 20 bits.
- RSTN=0 at bit 11 → next cycle all outputs 0, state IDLE, no config_done; new start → full clean frame.
- start asserted while busy is ignored; start coincident with config_done is accepted, giving a second frame whose first enable comes after its first word handshake.
- PARITY_EN: second word with wrong parity → parity_err=1 next cycle, enable drops after 8 bits, no config_done; next start clears parity_err.
